// File: rtl/kbd_char_sequencer.sv
// Converts KeyboardDecoder make/break events into 7-bit ASCII, tracks Caps Lock,
// and buffers characters in a FIFO exposed as a valid/ready stream.
module kbd_char_sequencer #(
  parameter int unsigned DEPTH     = 8,
  parameter bit          REPEAT_EN = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_key_valid,
  input  logic [8:0]              i_last_change,
  input  logic [511:0]            i_key_down,
  input  logic                    i_char_ready,
  output logic                    o_char_valid,
  output logic [6:0]              o_char_data,
  output logic                    o_caps_state,
  output logic [$clog2(DEPTH):0]  o_fifo_count,
  output logic                    o_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [8:0] SC_CAPS   = 9'h058;
  localparam logic [8:0] SC_LSHIFT = 9'h012;
  localparam logic [8:0] SC_RSHIFT = 9'h059;
  localparam logic [8:0] SC_SPACE  = 9'h029;
  localparam logic [8:0] SC_ENTER  = 9'h05A;

  logic          r_s1_vld;
  logic [8:0]    r_s1_code;
  logic          r_s1_press;
  logic          r_caps;
  logic [8:0]    r_last_make;
  logic          r_last_vld;
  logic [6:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_valid;
  logic          r_overflow;

  logic          w_letter_vld;
  logic [4:0]    w_letter_idx;
  logic          w_shift;
  logic          w_repeat;
  logic          w_make;
  logic          w_break;
  logic          w_caps_tgl;
  logic          w_push;
  logic [6:0]    w_push_data;
  logic          w_pop;
  logic          w_full;
  logic          w_wr;
  logic [CW-1:0] w_count_nxt;

  // Stage 1: capture the event and whether it was a press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld   <= 1'b0;
      r_s1_code  <= '0;
      r_s1_press <= 1'b0;
    end else begin
      r_s1_vld <= i_key_valid;
      if (i_key_valid) begin
        r_s1_code  <= i_last_change;
        r_s1_press <= i_key_down[i_last_change];
      end
    end
  end

  always_comb begin
    w_letter_vld = 1'b1;
    w_letter_idx = 5'd0;
    case (r_s1_code)
      9'h01C: w_letter_idx = 5'd0;
      9'h032: w_letter_idx = 5'd1;
      9'h021: w_letter_idx = 5'd2;
      9'h023: w_letter_idx = 5'd3;
      9'h024: w_letter_idx = 5'd4;
      9'h02B: w_letter_idx = 5'd5;
      9'h034: w_letter_idx = 5'd6;
      9'h033: w_letter_idx = 5'd7;
      9'h043: w_letter_idx = 5'd8;
      9'h03B: w_letter_idx = 5'd9;
      9'h042: w_letter_idx = 5'd10;
      9'h04B: w_letter_idx = 5'd11;
      9'h03A: w_letter_idx = 5'd12;
      9'h031: w_letter_idx = 5'd13;
      9'h044: w_letter_idx = 5'd14;
      9'h04D: w_letter_idx = 5'd15;
      9'h015: w_letter_idx = 5'd16;
      9'h02D: w_letter_idx = 5'd17;
      9'h01B: w_letter_idx = 5'd18;
      9'h02C: w_letter_idx = 5'd19;
      9'h03C: w_letter_idx = 5'd20;
      9'h02A: w_letter_idx = 5'd21;
      9'h01D: w_letter_idx = 5'd22;
      9'h022: w_letter_idx = 5'd23;
      9'h035: w_letter_idx = 5'd24;
      9'h01A: w_letter_idx = 5'd25;
      default: w_letter_vld = 1'b0;
    endcase
  end

  // Stage 2: classify the registered event; repeats of the last make are ignored
  always_comb begin
    w_shift     = i_key_down[SC_LSHIFT] | i_key_down[SC_RSHIFT];
    w_repeat    = !REPEAT_EN && r_last_vld && (r_last_make == r_s1_code);
    w_make      = r_s1_vld && r_s1_press && !w_repeat;
    w_break     = r_s1_vld && !r_s1_press;
    w_caps_tgl  = w_make && (r_s1_code == SC_CAPS);
    w_push      = 1'b0;
    w_push_data = 7'd0;
    if (w_make) begin
      if (w_letter_vld) begin
        w_push      = 1'b1;
        w_push_data = ((r_caps ^ w_shift) ? 7'd65 : 7'd97) + 7'(w_letter_idx);
      end else if (r_s1_code == SC_SPACE) begin
        w_push      = 1'b1;
        w_push_data = 7'd32;
      end else if (r_s1_code == SC_ENTER) begin
        w_push      = 1'b1;
        w_push_data = 7'd13;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_caps      <= 1'b0;
      r_last_make <= '0;
      r_last_vld  <= 1'b0;
    end else begin
      if (w_caps_tgl) r_caps <= ~r_caps;
      if (w_make) begin
        r_last_make <= r_s1_code;
        r_last_vld  <= 1'b1;
      end else if (w_break && r_last_vld && (r_last_make == r_s1_code)) begin
        r_last_vld <= 1'b0;
      end
    end
  end

  // FIFO: a push while full is only accepted when a pop frees the slot
  always_comb begin
    w_pop       = r_valid && i_char_ready;
    w_full      = (r_count == CW'(DEPTH));
    w_wr        = w_push && (!w_full || w_pop);
    w_count_nxt = r_count;
    if (w_wr && !w_pop)      w_count_nxt = r_count + CW'(1);
    else if (!w_wr && w_pop) w_count_nxt = r_count - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= w_push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign o_char_valid = r_valid;
  assign o_char_data  = r_mem[r_rd_ptr];
  assign o_caps_state = r_caps;
  assign o_fifo_count = r_count;
  assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_kbd_char_sequencer.sv
// Directed and randomized keystroke sequences checked against a transaction-level
// model of the character queue, Caps Lock state and sticky overflow.
module tb_kbd_char_sequencer;

  localparam int DEPTH = 8;

  logic         clk;
  logic         rst_n;
  logic         i_key_valid;
  logic [8:0]   i_last_change;
  logic [511:0] i_key_down;
  logic         i_char_ready;
  logic         o_char_valid;
  logic [6:0]   o_char_data;
  logic         o_caps_state;
  logic [3:0]   o_fifo_count;
  logic         o_overflow;

  kbd_char_sequencer #(.DEPTH(DEPTH), .REPEAT_EN(1'b0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_key_valid   (i_key_valid),
    .i_last_change (i_last_change),
    .i_key_down    (i_key_down),
    .i_char_ready  (i_char_ready),
    .o_char_valid  (o_char_valid),
    .o_char_data   (o_char_data),
    .o_caps_state  (o_caps_state),
    .o_fifo_count  (o_fifo_count),
    .o_overflow    (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int failures = 0;

  // Model state
  logic [511:0] kd;
  int           exp_q [$];
  bit           m_caps;
  bit           m_ov;
  int           m_last;
  logic [8:0]   let_codes [26] = '{9'h01C, 9'h032, 9'h021, 9'h023, 9'h024, 9'h02B, 9'h034,
                                   9'h033, 9'h043, 9'h03B, 9'h042, 9'h04B, 9'h03A, 9'h031,
                                   9'h044, 9'h04D, 9'h015, 9'h02D, 9'h01B, 9'h02C, 9'h03C,
                                   9'h02A, 9'h01D, 9'h022, 9'h035, 9'h01A};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int char_of(input logic [8:0] code, input bit up);
    for (int i = 0; i < 26; i++)
      if (let_codes[i] == code) return up ? 65 + i : 97 + i;
    if (code == 9'h029) return 32;
    if (code == 9'h05A) return 13;
    return -1;
  endfunction

  task automatic model_key(input logic [8:0] code, input bit press);
    int ch;
    if (press) begin
      if (m_last == int'(code)) return;
      m_last = int'(code);
      if (code == 9'h058) m_caps = ~m_caps;
      ch = char_of(code, m_caps ^ (kd[9'h012] | kd[9'h059]));
      if (ch >= 0) begin
        if (exp_q.size() >= DEPTH) m_ov = 1'b1;
        else exp_q.push_back(ch);
      end
    end else if (m_last == int'(code)) begin
      m_last = -1;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_caps = 1'b0;
    m_ov   = 1'b0;
    m_last = -1;
    kd     = '0;
  endtask

  // Drive one decoder event, then idle `gap` cycles
  task automatic key_evt(input logic [8:0] code, input bit press, input int gap);
    kd[code]      = press;
    i_key_down    = kd;
    i_last_change = code;
    i_key_valid   = 1'b1;
    @(negedge clk);
    i_key_valid = 1'b0;
    model_key(code, press);
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"}, 32'(o_fifo_count), 32'(exp_q.size()));
    chk({tag, "_valid"}, 32'(o_char_valid), 32'(exp_q.size() != 0));
    chk({tag, "_caps"},  32'(o_caps_state), 32'(m_caps));
    chk({tag, "_ovf"},   32'(o_overflow),   32'(m_ov));
    if (exp_q.size() != 0) chk({tag, "_data"}, 32'(o_char_data), 32'(exp_q[0]));
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (exp_q.size() == 0) break;
      chk({tag, "_dvalid"}, 32'(o_char_valid), 32'd1);
      chk({tag, "_ddata"},  32'(o_char_data),  32'(exp_q[0]));
      i_char_ready = 1'b1;
      @(negedge clk);
      i_char_ready = 1'b0;
      void'(exp_q.pop_front());
      chk({tag, "_dcount"}, 32'(o_fifo_count), 32'(exp_q.size()));
    end
    chk({tag, "_empty"}, 32'(o_char_valid), 32'd0);
  endtask

  initial begin
    logic [8:0] code;
    bit         press;
    int         r;

    rst_n = 1'b0; i_key_valid = 1'b0; i_last_change = '0;
    i_key_down = '0; i_char_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_state("reset");
    chk("reset_data", 32'(o_char_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Latency: 'a' appears exactly two cycles after key_valid
    kd[9'h01C] = 1'b1; i_key_down = kd; i_last_change = 9'h01C; i_key_valid = 1'b1;
    @(negedge clk);
    i_key_valid = 1'b0;
    model_key(9'h01C, 1'b1);
    chk("lat_n1_valid", 32'(o_char_valid), 32'd0);
    @(negedge clk);
    check_state("lat_n2");
    chk("lat_a", 32'(o_char_data), 32'd97);
    key_evt(9'h01C, 1'b0, 2);
    drain("a");
    i_char_ready = 1'b1;
    repeat (2) @(negedge clk);
    i_char_ready = 1'b0;
    chk("empty_ready_count", 32'(o_fifo_count), 32'd0);

    // Shift gives upper case, release returns to lower
    key_evt(9'h012, 1'b1, 2);
    key_evt(9'h032, 1'b1, 2);
    check_state("shift_B");
    chk("shift_B_val", 32'(o_char_data), 32'd66);
    key_evt(9'h032, 1'b0, 2);
    key_evt(9'h012, 1'b0, 2);
    key_evt(9'h032, 1'b1, 2);
    key_evt(9'h032, 1'b0, 2);
    drain("shift");

    // Caps on plus shift cancels to lower case
    key_evt(9'h058, 1'b1, 2);
    key_evt(9'h058, 1'b0, 2);
    key_evt(9'h012, 1'b1, 2);
    key_evt(9'h021, 1'b1, 2);
    check_state("caps_c");
    chk("caps_on", 32'(o_caps_state), 32'd1);
    chk("caps_c_val", 32'(o_char_data), 32'd99);
    key_evt(9'h021, 1'b0, 2);
    key_evt(9'h012, 1'b0, 2);
    drain("caps");

    // Repeats suppressed until a break
    for (int i = 0; i < 3; i++) key_evt(9'h01C, 1'b1, 2);
    check_state("rep3");
    key_evt(9'h01C, 1'b0, 2);
    key_evt(9'h01C, 1'b1, 2);
    check_state("rep_again");
    key_evt(9'h01C, 1'b0, 2);
    drain("rep");

    // Back-to-back events, one per clock
    key_evt(9'h024, 1'b1, 0);
    key_evt(9'h02B, 1'b1, 2);
    check_state("b2b");
    key_evt(9'h024, 1'b0, 0);
    key_evt(9'h02B, 1'b0, 2);
    drain("b2b");

    // Overflow with 9 letters, then simultaneous push/pop while full
    for (int i = 0; i < 9; i++) key_evt(let_codes[i], 1'b1, 2);
    check_state("full");
    chk("full_ovf", 32'(o_overflow), 32'd1);
    kd[9'h04B] = 1'b1; i_key_down = kd; i_last_change = 9'h04B; i_key_valid = 1'b1;
    @(negedge clk);
    i_key_valid = 1'b0; i_char_ready = 1'b1;
    @(negedge clk);
    i_char_ready = 1'b0;
    void'(exp_q.pop_front());
    model_key(9'h04B, 1'b1);
    check_state("pushpop");
    drain("full");
    for (int i = 0; i < 9; i++) key_evt(let_codes[i], 1'b0, 0);
    key_evt(9'h04B, 1'b0, 2);

    // Randomized keystrokes
    for (int n = 0; n < 200; n++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 5)      code = let_codes[$urandom_range(0, 25)];
      else if (r == 6) code = ($urandom_range(0, 1) != 0) ? 9'h012 : 9'h059;
      else if (r == 7) code = 9'h058;
      else if (r == 8) code = ($urandom_range(0, 1) != 0) ? 9'h029 : 9'h05A;
      else             code = 9'($urandom_range(0, 511));
      press = kd[code] ? ($urandom_range(0, 2) == 0) : 1'b1;
      key_evt(code, press, 2);
      check_state("rand");
      if ($urandom_range(0, 5) == 0) drain("rand");
    end
    drain("rand_end");

    // Reset mid-operation with queued characters
    key_evt(9'h058, 1'b1, 0);
    key_evt(9'h01C, 1'b1, 0);
    key_evt(9'h032, 1'b1, 0);
    key_evt(9'h021, 1'b1, 2);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_valid", 32'(o_char_valid), 32'd0);
    chk("midrst_count", 32'(o_fifo_count), 32'd0);
    chk("midrst_caps",  32'(o_caps_state), 32'd0);
    chk("midrst_ovf",   32'(o_overflow),   32'd0);
    i_key_down = '0;
    @(negedge clk);
    rst_n = 1'b1;
    key_evt(9'h01A, 1'b1, 2);
    check_state("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
